// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: command op-codes, FSM states and
// the reference-model update rule used by the optional Q checker.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck
  } jk_state_e;

  // Value a JK flip-flop holds after one clock of the given command.
  function automatic logic jk_next(input jk_op_e op, input logic cur);
    unique case (op)
      JK_SET:    return 1'b1;
      JK_RESET:  return 1'b0;
      JK_TOGGLE: return ~cur;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO for JK commands; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module jk_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[Aw-1:0]] = wdata_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Sequences queued JK commands onto a downstream flip-flop, one command per two
// cycles. Define JK_CMD_SEQ_CHECK_EN to build the Q-checking model (err, err_cnt).
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  output logic                 J,
  output logic                 K,
  input  logic                 Q,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  jk_state_e  state_q, state_d;
  jk_op_e     op_q, op_d;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [1:0] fifo_rdata;

  jk_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (cmd_valid),
    .wdata_i (cmd_op),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fifo_pop = 1'b0;
    J        = 1'b0;
    K        = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = jk_op_e'(fifo_rdata);
          state_d  = StDrive;
        end
      end
      StDrive: begin
        {J, K}  = op_q;
        state_d = StCheck;
      end
      StCheck: begin
        done = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = jk_op_e'(fifo_rdata);
          state_d  = StDrive;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= JK_HOLD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

`ifdef JK_CMD_SEQ_CHECK_EN
  logic                 exp_q, exp_d;
  logic                 exp_valid_q, exp_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // The model advances on the same edge the downstream flop samples J/K.
  always_comb begin
    exp_d       = exp_q;
    exp_valid_d = exp_valid_q;
    err_cnt_d   = err_cnt_q;
    err         = 1'b0;
    if (state_q == StDrive) begin
      exp_d = jk_next(op_q, exp_q);
      if (op_q == JK_SET || op_q == JK_RESET) exp_valid_d = 1'b1;
    end
    if (state_q == StCheck && exp_valid_q && (Q != exp_q)) begin
      err = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q       <= 1'b0;
      exp_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      exp_q       <= exp_d;
      exp_valid_q <= exp_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_q;
  assign unused_q = Q;
  assign err      = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule
